// File: rtl/img_buffer_if.sv
// rtl/img_buffer_if.sv - byte stream handshake into the image buffer
interface img_buffer_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_byte, output rx_valid, input rx_ready);
    modport slave  (input rx_byte, input rx_valid, output rx_ready);
endinterface

// File: rtl/img_buffer.sv
// rtl/img_buffer.sv - assembles NUM_BYTES incoming bytes into one wide image word
module img_buffer #(
    parameter int NUM_BYTES = 113,
    parameter int IMG_BITS  = NUM_BYTES * 8,
    localparam int CNT_W    = $clog2(NUM_BYTES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    img_buffer_if.slave         rx,
    input  logic                buf_clear,
    output logic [IMG_BITS-1:0] img_out,
    output logic                img_buffer_full,
    output logic [CNT_W-1:0]    byte_count,
    output logic                overflow
);

    localparam int LSB_W = $clog2(IMG_BITS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t           state;
    logic             accept;
    logic [LSB_W-1:0] wr_lsb;

    assign rx.rx_ready = (state != FULL);
    assign accept      = rx.rx_valid && rx.rx_ready && !buf_clear;

    // First accepted byte fills the top of the image; later bytes walk toward bit 0.
    assign wr_lsb = LSB_W'(IMG_BITS - 8 - 8 * int'(byte_count));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= EMPTY;
            byte_count      <= '0;
            img_out         <= '0;
            img_buffer_full <= 1'b0;
            overflow        <= 1'b0;
        end else if (buf_clear) begin
            state           <= EMPTY;
            byte_count      <= '0;
            img_out         <= '0;
            img_buffer_full <= 1'b0;
            overflow        <= 1'b0;
        end else if (accept) begin
            img_out[wr_lsb +: 8] <= rx.rx_byte;
            byte_count           <= byte_count + CNT_W'(1);
            if (byte_count == LAST_IDX) begin
                state           <= FULL;
                img_buffer_full <= 1'b1;
            end else begin
                state <= FILLING;
            end
        end else if (rx.rx_valid && state == FULL) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: doc/img_buffer.md
IMG_BUFFER -- requirements
Module: img_buffer

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 113, the number of bytes per image (113 x 8 = 904 bits).
REQ-002 SHALL have parameter IMG_BITS, default NUM_BYTES*8, the width of the assembled image.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx_byte, input, 8, the incoming image byte.
REQ-006 SHALL have port rx_valid, input, 1, qualifies rx_byte for one cycle.
REQ-007 SHALL have port rx_ready, output, 1, high when a byte offered this cycle will be accepted.
REQ-008 SHALL have port buf_clear, input, 1, synchronous request to empty the buffer.
REQ-009 SHALL have port img_out, output, IMG_BITS, the assembled image (feeds img_in of the BNN interface).
REQ-010 SHALL have port img_buffer_full, output, 1, high while a complete image is held.
REQ-011 SHALL have port byte_count, output, 7 (clog2(NUM_BYTES+1)), the number of bytes accepted since the last clear.
REQ-012 SHALL have port overflow, output, 1, sticky flag for a byte offered while full.

Function
REQ-013 SHALL implement FSM states EMPTY (count 0), FILLING (0 < count < NUM_BYTES) and FULL (count == NUM_BYTES).
REQ-014 SHALL accept a byte on a posedge where rx_valid && rx_ready && !buf_clear.
REQ-015 SHALL drive rx_ready = 1 in EMPTY and FILLING and 0 in FULL, combinationally from state only.
REQ-016 SHALL write byte k (0-based acceptance order) to img_out[IMG_BITS-1-8k -: 8], so the first byte lands in bits [903:896] and byte 112 lands in bits [7:0].
REQ-017 SHALL increment byte_count by exactly 1 per accepted byte and never exceed NUM_BYTES; there SHALL be no wrap-around.
REQ-018 SHALL transition EMPTY->FILLING on the first accepted byte, and FILLING->FULL on the accepted byte that makes count == NUM_BYTES.
REQ-019 SHALL assert img_buffer_full on the cycle after the final byte is accepted (1-cycle latency) and hold it until clear or reset.
REQ-020 SHALL hold img_out stable while FULL; bytes offered while FULL are dropped and SHALL set overflow on the next cycle.
REQ-021 SHALL, on buf_clear in any state, go to EMPTY on the next cycle, with byte_count = 0, img_out = all zeros, img_buffer_full = 0 and overflow = 0.
REQ-022 SHALL give buf_clear priority over rx_valid in the same cycle: the byte is dropped, is not counted and does not set overflow.
REQ-023 SHALL leave not-yet-written bits at zero during FILLING; img_out is meaningful to consumers only while img_buffer_full = 1.
REQ-024 SHALL ignore rx_byte entirely whenever rx_valid = 0.

Reset
REQ-025 SHALL, while rst_n = 0, asynchronously force state EMPTY, byte_count = 0, img_out = 0, img_buffer_full = 0 and overflow = 0; rx_ready then reads 1.
REQ-026 SHALL, on reset asserted mid-fill, discard any partial image; after release, the next accepted byte is byte 0.

Verification
REQ-027 SHALL be verified by: 113 back-to-back bytes 0x00..0x70 -> img_buffer_full = 1 one cycle after the last byte, img_out[903:896] = 0x00, img_out[7:0] = 0x70, byte_count = 113, rx_ready = 0.
REQ-028 SHALL be verified by: a full buffer plus 3 more valid bytes -> img_out unchanged, byte_count = 113, overflow = 1; then buf_clear -> byte_count = 0, overflow = 0, img_out = 0.
REQ-029 SHALL be verified by: 50 bytes, then buf_clear together with rx_valid (byte 0xAA) -> byte_count = 0 and 0xAA not present anywhere in img_out.
REQ-030 SHALL be verified by: 60 bytes, then rst_n pulsed low asynchronously between clock edges -> outputs zero immediately; 113 new bytes 0xFF -> img_out all ones, img_buffer_full = 1.
REQ-031 SHALL be verified by: bytes sent with random rx_valid gaps (113 valid out of about 300 cycles) -> image bit-exact against the reference model, img_buffer_full asserted exactly once.
